// File: rtl/jtcps_busgate_pkg.sv
// Shared definitions for the CPS main-CPU bus-cycle gate: FSM state
// encoding and width/saturation helpers.
package jtcps_busgate_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // Largest value a credit counter of crw bits can hold
   function automatic int unsigned credit_sat(input int unsigned crw);
      return (32'd1 << crw) - 32'd1;
   endfunction

   // Width of a region index; a single region still gets one bit
   function automatic int idx_width(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

endpackage

// File: rtl/jtcps_busgate_if.sv
// 68000 bus handshake bundle between the CPU side and the bus gate.
interface jtcps_busgate_if
   import jtcps_busgate_pkg::*;
#(
   parameter int CH = 4
) ();
   logic          cen;
   logic          ASn;
   logic [CH-1:0] cs;
   logic [CH-1:0] ok;
   logic          DTACKn;
   logic          BERRn;
   logic          busy;

   modport master (
      output cen, ASn, cs, ok,
      input  DTACKn, BERRn, busy
   );

   modport slave (
      input  cen, ASn, cs, ok,
      output DTACKn, BERRn, busy
   );
endinterface

// File: rtl/jtcps_prienc.sv
// Lowest-index-wins priority encoder with an explicit "nothing set" flag.
module jtcps_prienc
   import jtcps_busgate_pkg::*;
#(
   parameter int CH = 4,
   parameter int IW = idx_width(CH)
) (
   input  logic [CH-1:0] req_i,
   output logic [IW-1:0] idx_o,
   output logic          none_o
);

   // Scan from the top down so the lowest set request is the last writer
   always_comb begin
      idx_o  = '0;
      none_o = 1'b1;
      for (int i = CH - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o  = IW'(i);
            none_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/jtcps_busgate.sv
// Multi-region DTACKn/BERRn generator for the CPS main CPU. Each region
// has a fixed wait count and a level-sensitive ready line; cycles spent
// waiting on ready are banked as credit and repaid against later fixed waits.
module jtcps_busgate
   import jtcps_busgate_pkg::*;
#(
   parameter int CH  = 4,
   parameter int WW  = 2,
   parameter int CRW = 4,
   parameter int TOW = 8
) (
   input  logic              clk,
   input  logic              rst,
   jtcps_busgate_if.slave    bus,
   input  logic [CH*WW-1:0]  wait_cfg,
   input  logic              credit_en,
   output logic [CRW-1:0]    credit
);

   localparam int             IW       = idx_width(CH);
   localparam int             MW       = (CRW > WW) ? CRW : WW;
   localparam logic [CRW-1:0] CRED_MAX = CRW'(credit_sat(CRW));

   state_t         state_q,  state_d;
   logic [IW-1:0]  ch_q,     ch_d;
   logic           none_q,   none_d;
   logic [WW-1:0]  wcnt_q,   wcnt_d;
   logic [TOW-1:0] tocnt_q,  tocnt_d;
   logic [CRW-1:0] credit_q, credit_d;
   logic           dtackn_q, dtackn_d;
   logic           berrn_q,  berrn_d;

   logic [IW-1:0]  enc_idx;
   logic           enc_none;
   logic [WW-1:0]  wait_arr [CH];
   logic [WW-1:0]  wait_sel;
   logic [MW-1:0]  cred_ext, wait_ext, rep_ext;

   jtcps_prienc #(
      .CH (CH),
      .IW (IW)
   ) u_prienc (
      .req_i  (bus.cs),
      .idx_o  (enc_idx),
      .none_o (enc_none)
   );

   // Split the flat wait configuration into one entry per region
   for (genvar gi = 0; gi < CH; gi++) begin : g_wait
      assign wait_arr[gi] = wait_cfg[gi*WW +: WW];
   end

   // Repayment is capped by the fixed wait so wcnt never underflows
   assign wait_sel = wait_arr[enc_idx];
   assign cred_ext = MW'(credit_q);
   assign wait_ext = MW'(wait_sel);
   assign rep_ext  = !credit_en ? '0 : ((cred_ext < wait_ext) ? cred_ext : wait_ext);

   // Next-state logic: FSM plus wait, timeout and credit counters, gated by cen
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      none_d   = none_q;
      wcnt_d   = wcnt_q;
      tocnt_d  = tocnt_q;
      credit_d = credit_q;
      dtackn_d = dtackn_q;
      berrn_d  = berrn_q;
      if (bus.cen) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!bus.ASn) begin
                  ch_d   = enc_idx;
                  none_d = enc_none;
                  if (enc_none) begin
                     state_d  = ST_ACK;
                     dtackn_d = 1'b0;
                  end else begin
                     wcnt_d   = wait_sel - WW'(rep_ext);
                     credit_d = credit_q - CRW'(rep_ext);
                     tocnt_d  = '0;
                     state_d  = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // An aborted cycle leaves immediately; credit already banked stays
               if (bus.ASn) begin
                  state_d = ST_IDLE;
               end else if (wcnt_q != '0) begin
                  wcnt_d = wcnt_q - WW'(1);
               end else if (bus.ok[ch_q]) begin
                  state_d  = ST_ACK;
                  dtackn_d = 1'b0;
               end else begin
                  tocnt_d = tocnt_q + TOW'(1);
                  if (credit_en && credit_q != CRED_MAX) begin
                     credit_d = credit_q + CRW'(1);
                  end
                  if (tocnt_d == '1) begin
                     state_d = ST_HOLD;
                     berrn_d = 1'b0;
                  end
               end
            end
            ST_ACK: begin
               if (bus.ASn) begin
                  state_d  = ST_IDLE;
                  dtackn_d = 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.ASn) begin
                  state_d = ST_IDLE;
                  berrn_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State register; reset wins on any clock edge regardless of cen
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ch_q     <= '0;
         none_q   <= 1'b0;
         wcnt_q   <= '0;
         tocnt_q  <= '0;
         credit_q <= '0;
         dtackn_q <= 1'b1;
         berrn_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         none_q   <= none_d;
         wcnt_q   <= wcnt_d;
         tocnt_q  <= tocnt_d;
         credit_q <= credit_d;
         dtackn_q <= dtackn_d;
         berrn_q  <= berrn_d;
      end
   end

   assign bus.DTACKn = dtackn_q;
   assign bus.BERRn  = berrn_q;
   assign bus.busy   = (state_q == ST_WAIT) || (state_q == ST_HOLD);
   assign credit     = credit_q;

endmodule
